id_hazard_controller: RTL and testbench
=======================================

ID_HAZARD_CONTROLLER -- requirements
Module: id_hazard_controller

Interface
REQ-001 SHALL have parameter NREG_BITS, default 5, register-select width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, bubble cycles needed to empty EX/MEM/WB before halt.
REQ-003 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have i_id_rs, i_id_rt  input  NREG_BITS each  source selects of instruction in ID.
REQ-006 SHALL have i_id_use_rs, i_id_use_rt  input  1 each  instruction in ID reads rs / rt.
REQ-007 SHALL have i_id_branch  input  1  instruction in ID is a conditional branch, resolved in ID.
REQ-008 SHALL have i_ex_rd, i_mem_rd  input  NREG_BITS each  destinations in EX and MEM.
REQ-009 SHALL have i_ex_wr_en, i_mem_wr_en  input  1 each  EX / MEM instruction writes a register.
REQ-010 SHALL have i_ex_load, i_mem_load  input  1 each  EX / MEM instruction is a memory load.
REQ-011 SHALL have i_pc_redirect  input  1  taken branch or jump resolved in ID this cycle.
REQ-012 SHALL have i_halt_req  input  1  debug halt request, level.
REQ-013 SHALL have i_cnt_clr  input  1  synchronous clear of stall counter.
REQ-014 SHALL have o_pc_stall, o_ifid_stall  output  1 each  hold PC / IF_ID register.
REQ-015 SHALL have o_idex_bubble  output  1  load NOP into ID_EX register.
REQ-016 SHALL have o_ifid_flush  output  1  clear IF_ID register.
REQ-017 SHALL have o_halt_ack  output  1  pipeline empty and frozen.
REQ-018 SHALL have o_stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-019 SHALL define match(x) = x!=0 AND ((i_id_use_rs AND i_id_rs==x) OR (i_id_use_rt AND i_id_rt==x)).
REQ-020 SHALL raise hazard_1 when: i_ex_load AND i_ex_wr_en AND match(i_ex_rd); or i_id_branch AND i_ex_wr_en AND match(i_ex_rd); or i_id_branch AND i_mem_load AND i_mem_wr_en AND match(i_mem_rd).
REQ-021 SHALL raise hazard_2 (two-cycle stall) when i_id_branch AND i_ex_load AND i_ex_wr_en AND match(i_ex_rd); hazard_2 takes precedence over hazard_1.
REQ-022 SHALL implement FSM states RUN, STALL, DRAIN, HALTED.
REQ-023 RUN: hazard_2 -> STALL with remaining=1; hazard_1 -> stays RUN (re-evaluated next cycle); no hazard and i_halt_req -> DRAIN with drain counter = DRAIN_CYCLES-1.
REQ-024 In RUN/STALL, o_pc_stall = o_ifid_stall = o_idex_bubble = 1 in any cycle with a hazard or in STALL; combinational from state and inputs, zero added latency.
REQ-025 STALL: asserts stall outputs; remaining==0 -> RUN, else decrement.
REQ-026 o_ifid_flush SHALL equal i_pc_redirect AND NOT any stall output; a redirect during a stall is ignored (branch re-evaluates after stall).
REQ-027 DRAIN: o_pc_stall=1, o_ifid_stall=1, o_idex_bubble=1; counter reaches 0 -> HALTED; i_halt_req deasserting in DRAIN -> RUN.
REQ-028 HALTED: o_pc_stall=o_ifid_stall=o_idex_bubble=1, o_halt_ack=1; i_halt_req low -> RUN next cycle, o_halt_ack low in that RUN cycle.
REQ-029 i_halt_req during hazard or STALL SHALL be deferred until stall completes.
REQ-030 o_stall_cnt SHALL increment each cycle o_pc_stall=1 in RUN or STALL (not DRAIN/HALTED), saturate at 0xFFFF; i_cnt_clr wins over increment.

Reset
REQ-031 i_rst SHALL force state RUN, remaining 0, drain counter 0, o_stall_cnt 0, o_halt_ack 0 immediately; stall/flush outputs reflect RUN with current inputs.
REQ-032 Reset mid-STALL or mid-DRAIN SHALL abandon the operation with no residual stall cycles.

Structure
REQ-033 State encoding localparams and DRAIN_CYCLES default SHALL live in a shared pipeline package.
REQ-034 Hazard comparison (REQ-019..021) SHALL be a combinational sub-module hazard_detect; FSM and counters stay in id_hazard_controller.

Verification
REQ-035 EX load rd=5, ID use rs=5 -> exactly 1 cycle pc_stall/ifid_stall/idex_bubble; stall_cnt 0->1.
REQ-036 ID branch rs=7, EX load rd=7 -> 2 consecutive stall cycles, then RUN; stall_cnt=2.
REQ-037 EX load rd=0, ID use rs=0 -> no stall; i_pc_redirect=1 same cycle -> ifid_flush=1 for 1 cycle.
REQ-038 i_halt_req=1 in idle RUN -> 3 DRAIN cycles, halt_ack=1 in cycle 4; drop req -> ack=0 next cycle, stalls released.
REQ-039 i_halt_req during 2-cycle stall -> DRAIN begins after stall ends; i_rst asserted mid-DRAIN -> RUN, halt_ack=0, stall_cnt=0 immediately.
REQ-040 Force 65537 stall cycles -> stall_cnt holds 0xFFFF; i_cnt_clr with active stall -> 0.

Source files
------------

// File: rtl/id_hazard_controller_pkg.sv
// id_hazard_controller_pkg: shared pipeline-control types and constants.
package id_hazard_controller_pkg;
    localparam logic [1:0] RUN_ENC    = 2'd0;
    localparam logic [1:0] STALL_ENC  = 2'd1;
    localparam logic [1:0] DRAIN_ENC  = 2'd2;
    localparam logic [1:0] HALTED_ENC = 2'd3;
    typedef enum logic [1:0] {
        ST_RUN    = RUN_ENC,
        ST_STALL  = STALL_ENC,
        ST_DRAIN  = DRAIN_ENC,
        ST_HALTED = HALTED_ENC
    } state_t;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int DCNT_W           = 8;
    localparam int REM_W            = 2;
endpackage

// File: rtl/id_hazard_controller_hazard_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard detection for the ID stage.
module hazard_detect #(
    parameter int NREG_BITS = 5
) (
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_branch,
    input  logic [NREG_BITS-1:0] ex_rd,
    input  logic [NREG_BITS-1:0] mem_rd,
    input  logic                 ex_wr_en,
    input  logic                 mem_wr_en,
    input  logic                 ex_load,
    input  logic                 mem_load,
    output logic                 hazard_1,
    output logic                 hazard_2
);
    logic ex_match, mem_match;
    function automatic logic reads(input logic [NREG_BITS-1:0] x);
        return (x != '0) && ((id_use_rs && id_rs == x) || (id_use_rt && id_rt == x));
    endfunction
    always_comb begin
        ex_match  = ex_wr_en && reads(ex_rd);
        mem_match = mem_wr_en && mem_load && reads(mem_rd);
        hazard_2  = id_branch && ex_load && ex_match;
        hazard_1  = (ex_load && ex_match) || (id_branch && ex_match) || (id_branch && mem_match);
    end
endmodule

// File: rtl/id_hazard_controller.sv
// id_hazard_controller: ID-stage stall/flush sequencing, debug halt drain and stall-cycle counter.
module id_hazard_controller
    import id_hazard_controller_pkg::*;
#(
    parameter int NREG_BITS    = 5,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREG_BITS-1:0] i_id_rs,
    input  logic [NREG_BITS-1:0] i_id_rt,
    input  logic                 i_id_use_rs,
    input  logic                 i_id_use_rt,
    input  logic                 i_id_branch,
    input  logic [NREG_BITS-1:0] i_ex_rd,
    input  logic [NREG_BITS-1:0] i_mem_rd,
    input  logic                 i_ex_wr_en,
    input  logic                 i_mem_wr_en,
    input  logic                 i_ex_load,
    input  logic                 i_mem_load,
    input  logic                 i_pc_redirect,
    input  logic                 i_halt_req,
    input  logic                 i_cnt_clr,
    output logic                 o_pc_stall,
    output logic                 o_ifid_stall,
    output logic                 o_idex_bubble,
    output logic                 o_ifid_flush,
    output logic                 o_halt_ack,
    output logic [15:0]          o_stall_cnt
);
    state_t            state;
    logic [REM_W-1:0]  rem;
    logic [DCNT_W-1:0] dcnt;
    logic              haz_1, haz_2, stall, cnt_en;
    hazard_detect #(.NREG_BITS(NREG_BITS)) u_hazard_detect (
        .id_rs     (i_id_rs),
        .id_rt     (i_id_rt),
        .id_use_rs (i_id_use_rs),
        .id_use_rt (i_id_use_rt),
        .id_branch (i_id_branch),
        .ex_rd     (i_ex_rd),
        .mem_rd    (i_mem_rd),
        .ex_wr_en  (i_ex_wr_en),
        .mem_wr_en (i_mem_wr_en),
        .ex_load   (i_ex_load),
        .mem_load  (i_mem_load),
        .hazard_1  (haz_1),
        .hazard_2  (haz_2)
    );
    always_comb begin
        stall  = (state != ST_RUN) || haz_1 || haz_2;
        cnt_en = stall && (state == ST_RUN || state == ST_STALL);
    end
    assign o_pc_stall    = stall;
    assign o_ifid_stall  = stall;
    assign o_idex_bubble = stall;
    assign o_ifid_flush  = i_pc_redirect && !stall;
    // rem holds the STALL cycles still owed, including the current one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_RUN;
            rem         <= '0;
            dcnt        <= '0;
            o_halt_ack  <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            o_stall_cnt <= i_cnt_clr ? '0 : (cnt_en && o_stall_cnt != 16'hFFFF) ? o_stall_cnt + 16'd1 : o_stall_cnt;
            case (state)
                ST_RUN: begin
                    if (haz_2) begin
                        state <= ST_STALL;
                        rem   <= REM_W'(1);
                    end else if (!haz_1 && i_halt_req) begin
                        state <= ST_DRAIN;
                        dcnt  <= DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_STALL: begin
                    rem <= rem - REM_W'(1);
                    if (rem <= REM_W'(1)) state <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (!i_halt_req) begin
                        state <= ST_RUN;
                    end else if (dcnt == '0) begin
                        state      <= ST_HALTED;
                        o_halt_ack <= 1'b1;
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!i_halt_req) begin
                        state      <= ST_RUN;
                        o_halt_ack <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_id_hazard_controller.sv
// tb_id_hazard_controller: directed and randomized checks against a cycle-level behavioural model.
module tb_id_hazard_controller;
    localparam int DRAIN = 3;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [4:0]  i_id_rs, i_id_rt, i_ex_rd, i_mem_rd;
    logic        i_id_use_rs, i_id_use_rt, i_id_branch;
    logic        i_ex_wr_en, i_mem_wr_en, i_ex_load, i_mem_load;
    logic        i_pc_redirect, i_halt_req, i_cnt_clr;
    logic        o_pc_stall, o_ifid_stall, o_idex_bubble, o_ifid_flush, o_halt_ack;
    logic [15:0] o_stall_cnt;
    int checks = 0;
    int errors = 0;
    int extra = 0;
    int drain_left = 0;
    bit draining = 0;
    bit halted = 0;
    int m_cnt = 0;

    id_hazard_controller #(.NREG_BITS(5), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt), .i_id_branch(i_id_branch),
        .i_ex_rd(i_ex_rd), .i_mem_rd(i_mem_rd),
        .i_ex_wr_en(i_ex_wr_en), .i_mem_wr_en(i_mem_wr_en),
        .i_ex_load(i_ex_load), .i_mem_load(i_mem_load),
        .i_pc_redirect(i_pc_redirect), .i_halt_req(i_halt_req), .i_cnt_clr(i_cnt_clr),
        .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall), .o_idex_bubble(o_idex_bubble),
        .o_ifid_flush(o_ifid_flush), .o_halt_ack(o_halt_ack), .o_stall_cnt(o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic bit reads(input logic [4:0] x);
        return x != 0 && ((i_id_use_rs && i_id_rs == x) || (i_id_use_rt && i_id_rt == x));
    endfunction
    function automatic bit haz2();
        return i_id_branch && i_ex_load && i_ex_wr_en && reads(i_ex_rd);
    endfunction
    function automatic bit haz1();
        return (i_ex_load && i_ex_wr_en && reads(i_ex_rd)) || (i_id_branch && i_ex_wr_en && reads(i_ex_rd))
            || (i_id_branch && i_mem_load && i_mem_wr_en && reads(i_mem_rd));
    endfunction
    function automatic bit exp_stall();
        return extra > 0 || draining || halted || haz1() || haz2();
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            extra <= 0; draining <= 0; drain_left <= 0; halted <= 0; m_cnt <= 0;
        end else begin
            if (i_cnt_clr) m_cnt <= 0;
            else if (exp_stall() && !draining && !halted && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (halted) begin
                if (!i_halt_req) halted <= 0;
            end else if (draining) begin
                if (!i_halt_req) draining <= 0;
                else if (drain_left == 1) begin draining <= 0; halted <= 1; end
                else drain_left <= drain_left - 1;
            end else if (extra > 0) extra <= extra - 1;
            else if (haz2()) extra <= 1;
            else if (!haz1() && i_halt_req) begin draining <= 1; drain_left <= DRAIN; end
        end
    end

    always @(negedge i_clk) begin
        check("model_pc_stall", 32'(o_pc_stall), 32'(exp_stall()));
        check("model_ifid_stall", 32'(o_ifid_stall), 32'(exp_stall()));
        check("model_idex_bubble", 32'(o_idex_bubble), 32'(exp_stall()));
        check("model_ifid_flush", 32'(o_ifid_flush), 32'(i_pc_redirect && !exp_stall()));
        check("model_halt_ack", 32'(o_halt_ack), 32'(halted));
        check("model_stall_cnt", 32'(o_stall_cnt), 32'(m_cnt));
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask
    task automatic clear();
        {i_id_rs, i_id_rt, i_ex_rd, i_mem_rd} = '0;
        {i_id_use_rs, i_id_use_rt, i_id_branch, i_ex_wr_en, i_mem_wr_en} = '0;
        {i_ex_load, i_mem_load, i_pc_redirect, i_halt_req, i_cnt_clr} = '0;
    endtask
    task automatic set_load_use(input logic [4:0] r, input logic br);
        i_ex_load = 1; i_ex_wr_en = 1; i_ex_rd = r; i_id_use_rs = 1; i_id_rs = r; i_id_branch = br;
    endtask

    initial begin
        clear();
        repeat (2) @(negedge i_clk);
        check("reset_cnt", 32'(o_stall_cnt), 0);
        check("reset_ack", 32'(o_halt_ack), 0);
        check("reset_stall", 32'(o_pc_stall), 0);
        cyc(); i_rst = 0;
        cyc(); set_load_use(5'd5, 0);
        @(negedge i_clk); check("ld_use_stall", 32'(o_pc_stall), 1); check("ld_use_bubble", 32'(o_idex_bubble), 1); check("ld_use_cnt0", 32'(o_stall_cnt), 0);
        cyc(); clear();
        @(negedge i_clk); check("ld_use_release", 32'(o_pc_stall), 0); check("ld_use_cnt1", 32'(o_stall_cnt), 1);
        cyc(); i_cnt_clr = 1;
        cyc(); i_cnt_clr = 0;
        @(negedge i_clk); check("clr_cnt", 32'(o_stall_cnt), 0);
        cyc(); set_load_use(5'd7, 1);
        @(negedge i_clk); check("br_stall1", 32'(o_pc_stall), 1);
        cyc(); clear();
        @(negedge i_clk); check("br_stall2", 32'(o_ifid_stall), 1);
        cyc();
        @(negedge i_clk); check("br_release", 32'(o_pc_stall), 0); check("br_cnt", 32'(o_stall_cnt), 2);
        cyc(); set_load_use(5'd0, 0); i_pc_redirect = 1;
        @(negedge i_clk); check("r0_nostall", 32'(o_pc_stall), 0); check("r0_flush", 32'(o_ifid_flush), 1);
        cyc(); clear();
        @(negedge i_clk); check("flush_drop", 32'(o_ifid_flush), 0);
        cyc(); i_halt_req = 1;
        @(negedge i_clk); check("halt_run", 32'(o_pc_stall), 0);
        for (int k = 0; k < DRAIN; k++) begin
            cyc();
            @(negedge i_clk); check("drain_stall", 32'(o_pc_stall), 1); check("drain_ack", 32'(o_halt_ack), 0);
        end
        cyc();
        @(negedge i_clk); check("halted_ack", 32'(o_halt_ack), 1);
        cyc(); i_halt_req = 0;
        @(negedge i_clk); check("halted_last_ack", 32'(o_halt_ack), 1);
        cyc();
        @(negedge i_clk); check("unhalt_ack", 32'(o_halt_ack), 0); check("unhalt_stall", 32'(o_pc_stall), 0); check("halt_cnt", 32'(o_stall_cnt), 2);
        cyc(); set_load_use(5'd7, 1); i_halt_req = 1;
        @(negedge i_clk); check("def_stall1", 32'(o_pc_stall), 1);
        cyc(); clear(); i_halt_req = 1;
        @(negedge i_clk); check("def_stall2", 32'(o_pc_stall), 1); check("def_ack", 32'(o_halt_ack), 0);
        cyc();
        @(negedge i_clk); check("def_run", 32'(o_pc_stall), 0);
        cyc();
        @(negedge i_clk); check("def_drain", 32'(o_pc_stall), 1); check("def_cnt", 32'(o_stall_cnt), 4);
        cyc(); i_rst = 1;
        @(negedge i_clk); check("rst_ack", 32'(o_halt_ack), 0); check("rst_cnt", 32'(o_stall_cnt), 0); check("rst_stall", 32'(o_pc_stall), 0);
        cyc(); i_rst = 0; i_halt_req = 0;
        repeat (3000) begin
            cyc();
            i_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) i_halt_req = ~i_halt_req;
            i_cnt_clr = ($urandom_range(0, 49) == 0);
            i_id_rs = 5'($urandom_range(0, 3)); i_id_rt = 5'($urandom_range(0, 3));
            i_ex_rd = 5'($urandom_range(0, 3)); i_mem_rd = 5'($urandom_range(0, 3));
            {i_id_use_rs, i_id_use_rt, i_id_branch} = 3'($urandom_range(0, 7));
            {i_ex_wr_en, i_mem_wr_en, i_ex_load, i_mem_load} = 4'($urandom_range(0, 15));
            i_pc_redirect = 1'($urandom_range(0, 1));
        end
        cyc(); clear(); i_rst = 0; i_cnt_clr = 1;
        cyc(); i_cnt_clr = 0; set_load_use(5'd5, 0);
        repeat (65537) cyc();
        @(negedge i_clk); check("sat_cnt", 32'(o_stall_cnt), 32'hFFFF);
        i_cnt_clr = 1;
        cyc();
        @(negedge i_clk); check("sat_clr", 32'(o_stall_cnt), 0); check("sat_clr_stall", 32'(o_pc_stall), 1);
        cyc(); clear();
        @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
